// File: rtl/if_prefetch_pkg.sv
// Shared definitions for the instruction-fetch prefetch front end.
package if_prefetch_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int PC_STEP    = 4;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // RUN fetches normally; DRAIN swallows responses issued before a redirect.
  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Small synchronous FIFO used both for fetched {addr, inst} pairs and for
// the in-flight request address queue. Clear wins over push.
module if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && !clear && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear behaves like a reset of the queue.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Upstream flow control must never offer data to a full queue.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop && !clear));

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: PC generation, ROM request issue, response
// buffering and redirect draining.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_en_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic              rom_req_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_rvalid_i,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_stall_cnt_o,
  output logic [15:0]       flush_cnt_o
`endif
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic [CNT_W-1:0]    stale_q, stale_d;

  logic                issue;
  logic                resp_live;
  logic                inst_pop;
  logic [CNT_W:0]      in_flight;

  logic [ENTRY_W-1:0]  fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  logic [ADDR_W-1:0]   aq_head;
  logic                aq_full;
  logic                aq_empty;
  logic [CNT_W-1:0]    aq_count;
  logic                unused_status;

  assign unused_status = ^{aq_full, aq_empty, aq_count, fifo_full};
  assign in_flight     = {1'b0, fifo_count} + {1'b0, outstanding_q};

  // Next-state logic: a jump overrides everything, otherwise RUN fetches and DRAIN discards.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    stale_d       = stale_q;
    issue         = 1'b0;
    resp_live     = 1'b0;
    inst_pop      = 1'b0;
    if (jump_flag_i) begin
      pc_d          = jump_addr_i;
      outstanding_d = '0;
      stale_d       = stale_q + outstanding_q - CNT_W'(rom_rvalid_i);
      state_d       = (stale_d != '0) ? DRAIN : RUN;
    end else begin
      case (state_q)
        RUN: begin
          issue         = (in_flight < (CNT_W + 1)'(DEPTH));
          resp_live     = rom_rvalid_i;
          inst_pop      = inst_valid_o && !hold_en_i;
          if (issue) pc_d = pc_q + ADDR_W'(PC_STEP);
          outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(resp_live);
        end
        DRAIN: begin
          inst_pop = inst_valid_o && !hold_en_i;
          if (rom_rvalid_i) stale_d = stale_q - CNT_W'(1);
          if (stale_d == '0) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      stale_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
    end
  end

  assign rom_req_o  = issue && !rst;
  assign rom_addr_o = pc_q;

  if_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_addr_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (jump_flag_i),
    .push      (rom_req_o),
    .push_data (rom_addr_o),
    .pop       (resp_live),
    .head      (aq_head),
    .full      (aq_full),
    .empty     (aq_empty),
    .count     (aq_count)
  );

  if_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (jump_flag_i),
    .push      (resp_live),
    .push_data ({aq_head, rom_data_i}),
    .pop       (inst_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign inst_valid_o = !fifo_empty;
  assign inst_o       = inst_valid_o ? fifo_head[DATA_W-1:0] : DATA_W'(INST_NOP);
  assign inst_addr_o  = inst_valid_o ? fifo_head[ENTRY_W-1:DATA_W] : '0;

`ifdef IF_PERF_CNT_EN
  // Starved-pipeline counter (saturating) and redirect counter (wrapping).
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_stall_cnt_o <= '0;
      flush_cnt_o       <= '0;
    end else begin
      if (!hold_en_i && !inst_valid_o && (fetch_stall_cnt_o != 32'hFFFF_FFFF))
        fetch_stall_cnt_o <= fetch_stall_cnt_o + 32'd1;
      if (jump_flag_i)
        flush_cnt_o <= flush_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch with an in-order fixed-latency ROM model.
module tb_if_prefetch;
  import if_prefetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold_en_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_rvalid_i;
  logic [31:0] rom_data_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_stall_cnt_o;
  logic [15:0] flush_cnt_o;
`endif

  int errors = 0;
  int checks = 0;
  int per    = 0;
  int lat    = 1;

  logic [31:0] rom_q_addr[$];
  int          rom_q_due[$];

  typedef struct {
    logic        hold;
    logic        jump;
    logic [31:0] jaddr;
    logic        req;
    logic [31:0] raddr;
    logic        valid;
    logic [31:0] iaddr;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  if_prefetch dut (
    .clk          (clk),
    .rst          (rst),
    .hold_en_i    (hold_en_i),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .rom_req_o    (rom_req_o),
    .rom_addr_o   (rom_addr_o),
    .rom_rvalid_i (rom_rvalid_i),
    .rom_data_i   (rom_data_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_stall_cnt_o (fetch_stall_cnt_o),
    .flush_cnt_o       (flush_cnt_o)
`endif
  );

  function automatic logic [31:0] romWord(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive the cycle's inputs and the ROM response due in this cycle.
  task automatic applyStimulus(input logic hold, input logic jump, input logic [31:0] jaddr);
    hold_en_i    = hold;
    jump_flag_i  = jump;
    jump_addr_i  = jaddr;
    rom_rvalid_i = 1'b0;
    rom_data_i   = '0;
    if (rom_q_addr.size() > 0 && rom_q_due[0] <= per) begin
      rom_rvalid_i = 1'b1;
      rom_data_i   = romWord(rom_q_addr[0]);
      void'(rom_q_addr.pop_front());
      void'(rom_q_due.pop_front());
    end
    #1;
  endtask

  // Capture any accepted request, then advance to the next negedge.
  task automatic finishCycle();
    if (rom_req_o && !rst) begin
      rom_q_addr.push_back(rom_addr_o);
      rom_q_due.push_back(per + lat);
    end
    @(posedge clk);
    per++;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst          = 1'b1;
    hold_en_i    = 1'b0;
    jump_flag_i  = 1'b0;
    jump_addr_i  = '0;
    rom_rvalid_i = 1'b0;
    rom_data_i   = '0;
    rom_q_addr.delete();
    rom_q_due.delete();
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset req",   32'(rom_req_o),    32'h0);
    checkOutput("reset raddr", rom_addr_o,        32'h0);
    checkOutput("reset valid", 32'(inst_valid_o), 32'h0);
    checkOutput("reset inst",  inst_o,            INST_NOP);
    checkOutput("reset iaddr", inst_addr_o,       32'h0);
`ifdef IF_PERF_CNT_EN
    checkOutput("reset stall_cnt", fetch_stall_cnt_o, 32'h0);
    checkOutput("reset flush_cnt", 32'(flush_cnt_o),  32'h0);
`endif
    rst = 1'b0;
    per = 0;
  endtask

  task automatic checkCycle(input string tag, input logic req, input logic [31:0] raddr,
                            input logic valid, input logic [31:0] iaddr);
    checkOutput({tag, " req"},   32'(rom_req_o),    32'(req));
    if (req) checkOutput({tag, " raddr"}, rom_addr_o, raddr);
    checkOutput({tag, " valid"}, 32'(inst_valid_o), 32'(valid));
    checkOutput({tag, " iaddr"}, inst_addr_o,       valid ? iaddr : 32'h0);
    checkOutput({tag, " inst"},  inst_o,            valid ? romWord(iaddr) : INST_NOP);
  endtask

  // Run unheld until the first valid head; it must be exp_addr after exp_wait cycles.
  task automatic waitFirstValid(input string tag, input logic [31:0] exp_addr,
                                input int max_cycles, input int exp_wait);
    bit found = 1'b0;
    for (int k = 0; k < max_cycles && !found; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      if (inst_valid_o) begin
        found = 1'b1;
        checkOutput({tag, " first iaddr"}, inst_addr_o, exp_addr);
        checkOutput({tag, " first inst"},  inst_o,      romWord(exp_addr));
        checkOutput({tag, " first wait"},  k,           exp_wait);
      end
      finishCycle();
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: no valid within %0d cycles, expected addr %h", tag, max_cycles, exp_addr);
    end
  endtask

  task automatic addVec(input logic h, input logic j, input logic [31:0] ja, input logic rq,
                        input logic [31:0] ra, input logic v, input logic [31:0] ia);
    vec_t t;
    t.hold = h; t.jump = j; t.jaddr = ja; t.req = rq; t.raddr = ra; t.valid = v; t.iaddr = ia;
    vecs.push_back(t);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Latency-1 stream: startup, 5-cycle hold with head 0x8, jump coinciding with rvalid.
    addVec(0, 0, 32'h0,   1, 32'h0,   0, 32'h0);
    addVec(0, 0, 32'h0,   1, 32'h4,   0, 32'h0);
    addVec(0, 0, 32'h0,   0, 32'h8,   1, 32'h0);
    addVec(0, 0, 32'h0,   1, 32'h8,   1, 32'h4);
    addVec(0, 0, 32'h0,   1, 32'hC,   0, 32'h0);
    addVec(1, 0, 32'h0,   0, 32'h10,  1, 32'h8);
    addVec(1, 0, 32'h0,   0, 32'h10,  1, 32'h8);
    addVec(1, 0, 32'h0,   0, 32'h10,  1, 32'h8);
    addVec(1, 0, 32'h0,   0, 32'h10,  1, 32'h8);
    addVec(1, 0, 32'h0,   0, 32'h10,  1, 32'h8);
    addVec(0, 0, 32'h0,   0, 32'h10,  1, 32'h8);
    addVec(0, 0, 32'h0,   1, 32'h10,  1, 32'hC);
    addVec(0, 0, 32'h0,   1, 32'h14,  0, 32'h0);
    addVec(0, 0, 32'h0,   0, 32'h18,  1, 32'h10);
    addVec(0, 0, 32'h0,   1, 32'h18,  1, 32'h14);
    addVec(0, 1, 32'h200, 0, 32'h1C,  0, 32'h0);
    addVec(0, 0, 32'h0,   1, 32'h200, 0, 32'h0);
    addVec(0, 0, 32'h0,   1, 32'h204, 0, 32'h0);
    addVec(0, 0, 32'h0,   0, 32'h208, 1, 32'h200);
    addVec(0, 0, 32'h0,   1, 32'h208, 1, 32'h204);

    @(negedge clk);
    lat = 1;
    doReset();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].hold, vecs[i].jump, vecs[i].jaddr);
      checkCycle($sformatf("vec%0d", i), vecs[i].req, vecs[i].raddr, vecs[i].valid, vecs[i].iaddr);
      finishCycle();
    end

    // Latency 4, two outstanding, jump to 0x100: both stale responses drained.
    lat = 4;
    doReset();
    applyStimulus(0, 0, 32'h0);   checkCycle("l4 c0", 1, 32'h0, 0, 32'h0);   finishCycle();
    applyStimulus(0, 0, 32'h0);   checkCycle("l4 c1", 1, 32'h4, 0, 32'h0);   finishCycle();
    applyStimulus(0, 1, 32'h100); checkCycle("l4 jump", 0, 32'h8, 0, 32'h0); finishCycle();
    applyStimulus(0, 0, 32'h0);   checkCycle("l4 drain0", 0, 32'h100, 0, 32'h0); finishCycle();
    applyStimulus(0, 0, 32'h0);   checkCycle("l4 drain1", 0, 32'h100, 0, 32'h0); finishCycle();
    applyStimulus(0, 0, 32'h0);   checkCycle("l4 drain2", 0, 32'h100, 0, 32'h0); finishCycle();
    applyStimulus(0, 0, 32'h0);   checkCycle("l4 resume", 1, 32'h100, 0, 32'h0); finishCycle();
    waitFirstValid("l4", 32'h100, 12, 4);

    // Latency 2, jump in the same cycle as a response: stale drops to one.
    lat = 2;
    doReset();
    applyStimulus(0, 0, 32'h0);   checkCycle("l2 c0", 1, 32'h0, 0, 32'h0);   finishCycle();
    applyStimulus(0, 0, 32'h0);   checkCycle("l2 c1", 1, 32'h4, 0, 32'h0);   finishCycle();
    applyStimulus(0, 1, 32'h300); checkCycle("l2 jump", 0, 32'h8, 0, 32'h0); finishCycle();
    applyStimulus(0, 0, 32'h0);   checkCycle("l2 drain", 0, 32'h300, 0, 32'h0); finishCycle();
    applyStimulus(0, 0, 32'h0);   checkCycle("l2 resume", 1, 32'h300, 0, 32'h0); finishCycle();
    waitFirstValid("l2", 32'h300, 10, 2);

    // Reset while draining two stale responses.
    lat = 4;
    doReset();
    applyStimulus(0, 0, 32'h0);   finishCycle();
    applyStimulus(0, 0, 32'h0);   finishCycle();
    applyStimulus(0, 1, 32'h100); finishCycle();
    applyStimulus(0, 0, 32'h0);   checkCycle("rd drain", 0, 32'h100, 0, 32'h0); finishCycle();
    doReset();
    applyStimulus(0, 0, 32'h0);   checkCycle("rd run", 1, 32'h0, 0, 32'h0); finishCycle();
    waitFirstValid("rd", 32'h0, 12, 4);

    // Jump and hold together: the held head is flushed.
    lat = 1;
    doReset();
    applyStimulus(1, 0, 32'h0);   checkCycle("jh c0", 1, 32'h0, 0, 32'h0); finishCycle();
    applyStimulus(1, 0, 32'h0);   checkCycle("jh c1", 1, 32'h4, 0, 32'h0); finishCycle();
    applyStimulus(1, 0, 32'h0);   checkCycle("jh c2", 0, 32'h8, 1, 32'h0); finishCycle();
    applyStimulus(1, 0, 32'h0);   checkCycle("jh c3", 0, 32'h8, 1, 32'h0); finishCycle();
    applyStimulus(1, 1, 32'h400); checkCycle("jh jump", 0, 32'h8, 1, 32'h0); finishCycle();
    applyStimulus(1, 0, 32'h0);   checkCycle("jh after", 1, 32'h400, 0, 32'h0); finishCycle();
    waitFirstValid("jh", 32'h400, 10, 1);

`ifdef IF_PERF_CNT_EN
    // Three starved unheld cycles and two jumps.
    lat = 1;
    doReset();
    applyStimulus(0, 1, 32'h40); finishCycle();
    applyStimulus(0, 1, 32'h80); finishCycle();
    applyStimulus(0, 0, 32'h0);  finishCycle();
    applyStimulus(1, 0, 32'h0);  finishCycle();
    applyStimulus(1, 0, 32'h0);
    checkOutput("perf valid",     32'(inst_valid_o), 32'h1);
    checkOutput("perf stall_cnt", fetch_stall_cnt_o, 32'd3);
    checkOutput("perf flush_cnt", 32'(flush_cnt_o),  32'd2);
    finishCycle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
